// File: rtl/wb_regfile_pkg.sv
// Shared constants, writeback-select encoding and record types for wb_regfile.
// Trace records are only consumed when WB_TRACE_EN is defined.
package wb_regfile_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int RETW  = 64;
  localparam int AW    = $clog2(NREGS);

  localparam logic [AW-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    WB_SEL_ALU = 1'b0,
    WB_SEL_MEM = 1'b1
  } wbSel_e;

  // Single write port request into the register array.
  typedef struct packed {
    logic            we;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wrReq_t;

  // One retired instruction as seen by the trace port.
  typedef struct packed {
    logic [31:0]     instr;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] value;
  } traceRec_t;

  function automatic logic [XLEN-1:0] wbSelect(input wbSel_e sel,
                                               input logic [XLEN-1:0] aluVal,
                                               input logic [XLEN-1:0] memVal);
    return (sel == WB_SEL_MEM) ? memVal : aluVal;
  endfunction

endpackage

// File: rtl/wb_regfile_2r1w.sv
// regfile_2r1w: NR x DW storage, one write port, NRD combinational read ports
// with same-cycle write-to-read bypass. Entry 0 is never written and reads 0.
module regfile_2r1w
  import wb_regfile_pkg::*;
#(
  parameter int DW  = XLEN,
  parameter int NR  = NREGS,
  parameter int NRD = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  wrReq_t                        wrReq,
  input  logic [NRD-1:0][AW-1:0]        rdAddr,
  output logic [NRD-1:0][DW-1:0]        rdData
);

  logic [DW-1:0] regs [NR];

  // Storage update: synchronous clear on reset, otherwise single qualified write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NR; i++) regs[i] <= '0;
    end else if (wrReq.we && (wrReq.addr != REG_ZERO)) begin
      regs[wrReq.addr] <= wrReq.data;
    end
  end

  // Per-port read: x0 forced to zero, then bypass of the in-flight write, then storage.
  for (genvar p = 0; p < NRD; p++) begin : gRd
    assign rdData[p] = (rdAddr[p] == REG_ZERO)                 ? '0          :
                       (wrReq.we && (rdAddr[p] == wrReq.addr)) ? wrReq.data  :
                                                                 regs[rdAddr[p]];
  end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback mux, write qualifier, 32x32 register file with two
// bypassed read ports and a 64-bit retired-instruction counter.
// Optional trace port enabled by defining WB_TRACE_EN.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            wb_valid,
  input  logic [XLEN-1:0] wb_alu_out,
  input  logic [XLEN-1:0] wb_data_out,
  input  logic [4:0]      wb_rd,
  input  logic            wb_reg_write,
  input  logic            wb_mem_to_reg,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] wb_value,
`ifdef WB_TRACE_EN
  input  logic [31:0]     wb_instr,
  output logic            trace_valid,
  output logic [31:0]     trace_instr,
  output logic [4:0]      trace_rd,
  output logic [XLEN-1:0] trace_value,
`endif
  output logic [RETW-1:0] retire_count
);

  logic                     retire;
  logic                     we;
  wrReq_t                   wrReq;
  logic [1:0][AW-1:0]       rdAddr;
  logic [1:0][XLEN-1:0]     rdData;
  logic [RETW-1:0]          retireCnt;

  // Writeback value is exported unconditionally for EX forwarding.
  assign wb_value = wbSelect(wbSel_e'(wb_mem_to_reg), wb_alu_out, wb_data_out);

  // A stalled slot or a bubble never writes, counts, or bypasses.
  assign retire = en & wb_valid;
  assign we     = retire & wb_reg_write & (wb_rd != REG_ZERO);

  assign wrReq  = '{we: we, addr: wb_rd, data: wb_value};
  assign rdAddr = {rs2_addr, rs1_addr};

  regfile_2r1w #(.DW(XLEN), .NR(NREGS), .NRD(2)) uRf (
    .clk    (clk),
    .rst    (rst),
    .wrReq  (wrReq),
    .rdAddr (rdAddr),
    .rdData (rdData)
  );

  assign rs1_data = rdData[0];
  assign rs2_data = rdData[1];

  // Retire counter: one per valid, non-stalled slot; wraps silently.
  always_ff @(posedge clk) begin
    if (!rst)        retireCnt <= '0;
    else if (retire) retireCnt <= retireCnt + 1'b1;
  end

  assign retire_count = retireCnt;

`ifdef WB_TRACE_EN
  localparam int STAGES = 1;

  logic [STAGES:0] vld_pipe;
  traceRec_t       traceQ;

  assign vld_pipe[0] = retire;

  // Trace record capture: rd/value zeroed when the retiring slot did not write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe[STAGES:1] <= '0;
      traceQ             <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (retire) begin
        traceQ.instr <= wb_instr;
        traceQ.rd    <= we ? wb_rd    : REG_ZERO;
        traceQ.value <= we ? wb_value : '0;
      end
    end
  end

  assign trace_valid = vld_pipe[STAGES];
  assign trace_instr = traceQ.instr;
  assign trace_rd    = traceQ.rd;
  assign trace_value = traceQ.value;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile (default build; trace ports
// connected only when WB_TRACE_EN is defined).
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        wb_valid;
  logic [31:0] wb_alu_out;
  logic [31:0] wb_data_out;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        wb_mem_to_reg;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] wb_value;
  logic [63:0] retire_count;
`ifdef WB_TRACE_EN
  logic [31:0] wb_instr = '0;
  logic        trace_valid;
  logic [31:0] trace_instr;
  logic [4:0]  trace_rd;
  logic [31:0] trace_value;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .wb_valid      (wb_valid),
    .wb_alu_out    (wb_alu_out),
    .wb_data_out   (wb_data_out),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_mem_to_reg (wb_mem_to_reg),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .wb_value      (wb_value),
`ifdef WB_TRACE_EN
    .wb_instr      (wb_instr),
    .trace_valid   (trace_valid),
    .trace_instr   (trace_instr),
    .trace_rd      (trace_rd),
    .trace_value   (trace_value),
`endif
    .retire_count  (retire_count)
  );

  // Advance one edge; inputs change and outputs are sampled 1ns after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b1; wb_valid = 1'b0; wb_reg_write = 1'b0; wb_mem_to_reg = 1'b0;
    wb_alu_out = '0; wb_data_out = '0; wb_rd = '0;
  endtask

  task automatic drive_wr(input logic [4:0] rd, input logic [31:0] alu,
                          input logic [31:0] mem, input logic sel);
    en = 1'b1; wb_valid = 1'b1; wb_reg_write = 1'b1;
    wb_rd = rd; wb_alu_out = alu; wb_data_out = mem; wb_mem_to_reg = sel;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_wr(5'd1, 32'hAAAA_5555, 32'h0, 1'b0);
    rs1_addr = 5'd1; rs2_addr = 5'd2;
    tick(); tick();
    rst = 1'b1; idle();
    #1;
    for (int r = 1; r < 32; r++) begin
      rs1_addr = 5'(r); rs2_addr = 5'(r);
      #1;
      checks++;
      if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_x%0d: rs1=%h rs2=%h expected 0", r, rs1_data, rs2_data);
      end
    end
    checks++;
    if (retire_count !== 64'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", retire_count);
    end
  endtask

  task automatic test_write_read();
    drive_wr(5'd5, 32'hDEAD_BEEF, 32'h0, 1'b0);
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    tick();
    idle(); rs1_addr = 5'd5;
    #1;
    checks++;
    if (rs1_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_read_x5: got %h expected deadbeef", rs1_data);
    end
    checks++;
    if (retire_count !== 64'd1) begin
      errors++;
      $display("FAIL write_read_count: got %0d expected 1", retire_count);
    end
  endtask

  task automatic test_load_bypass();
    drive_wr(5'd7, 32'h0000_0BAD, 32'h1234_5678, 1'b1);
    rs1_addr = 5'd7; rs2_addr = 5'd7;
    #1;
    checks++;
    if (wb_value !== 32'h1234_5678) begin
      errors++;
      $display("FAIL load_sel_wb_value: got %h expected 12345678", wb_value);
    end
    checks++;
    if (rs1_data !== 32'h1234_5678 || rs2_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL load_bypass: rs1=%h rs2=%h expected 12345678", rs1_data, rs2_data);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rs1_data !== 32'h1234_5678 || rs2_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL load_persist: rs1=%h rs2=%h expected 12345678", rs1_data, rs2_data);
    end
    checks++;
    if (retire_count !== 64'd2) begin
      errors++;
      $display("FAIL load_count: got %0d expected 2", retire_count);
    end
  endtask

  task automatic test_x0();
    drive_wr(5'd0, 32'hFFFF_FFFF, 32'h0, 1'b0);
    rs1_addr = 5'd0; rs2_addr = 5'd5;
    #1;
    checks++;
    if (rs1_data !== 32'h0) begin
      errors++;
      $display("FAIL x0_same_cycle: got %h expected 0", rs1_data);
    end
    checks++;
    if (rs2_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL x0_no_alias: rs2=%h expected deadbeef", rs2_data);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rs1_data !== 32'h0) begin
      errors++;
      $display("FAIL x0_after: got %h expected 0", rs1_data);
    end
    checks++;
    if (retire_count !== 64'd3) begin
      errors++;
      $display("FAIL x0_count: got %0d expected 3", retire_count);
    end
  endtask

  task automatic test_stall_bubble();
    drive_wr(5'd3, 32'h0000_0011, 32'h0, 1'b0);
    tick();
    // stall with a write to x3
    drive_wr(5'd3, 32'h0000_0055, 32'h0, 1'b0);
    en = 1'b0; rs1_addr = 5'd3;
    #1;
    checks++;
    if (rs1_data !== 32'h11 || wb_value !== 32'h55) begin
      errors++;
      $display("FAIL stall_no_bypass: rs1=%h wb_value=%h expected 11/55", rs1_data, wb_value);
    end
    tick();
    checks++;
    if (rs1_data !== 32'h11 || retire_count !== 64'd4) begin
      errors++;
      $display("FAIL stall_frozen: rs1=%h count=%0d expected 11/4", rs1_data, retire_count);
    end
    // bubble with write request asserted
    en = 1'b1; wb_valid = 1'b0;
    #1;
    checks++;
    if (rs1_data !== 32'h11) begin
      errors++;
      $display("FAIL bubble_no_bypass: rs1=%h expected 11", rs1_data);
    end
    tick();
    checks++;
    if (rs1_data !== 32'h11 || retire_count !== 64'd4) begin
      errors++;
      $display("FAIL bubble_frozen: rs1=%h count=%0d expected 11/4", rs1_data, retire_count);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    drive_wr(5'd10, 32'h0000_0001, 32'h0, 1'b0);
    tick();
    drive_wr(5'd11, 32'h0000_0002, 32'h0, 1'b0);
    rs1_addr = 5'd10; rs2_addr = 5'd11;
    #1;
    checks++;
    if (rs1_data !== 32'h1 || rs2_data !== 32'h2) begin
      errors++;
      $display("FAIL b2b_read: rs1=%h rs2=%h expected 1/2", rs1_data, rs2_data);
    end
    tick();
    // store-like slot: valid, no register write, still retires
    drive_wr(5'd12, 32'h0000_0077, 32'h0, 1'b0);
    wb_reg_write = 1'b0; rs1_addr = 5'd12;
    #1;
    checks++;
    if (rs1_data !== 32'h0) begin
      errors++;
      $display("FAIL store_no_bypass: rs1=%h expected 0", rs1_data);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rs1_data !== 32'h0 || retire_count !== 64'd7) begin
      errors++;
      $display("FAIL store_retire: rs1=%h count=%0d expected 0/7", rs1_data, retire_count);
    end
  endtask

  task automatic test_wrap_and_reset();
    force dut.retireCnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retireCnt;
    en = 1'b1; wb_valid = 1'b1; wb_reg_write = 1'b0;
    tick();
    idle();
    #1;
    checks++;
    if (retire_count !== 64'd0) begin
      errors++;
      $display("FAIL wrap: got %h expected 0", retire_count);
    end
    // a few retires, then reset mid-stream with a pending write
    drive_wr(5'd9, 32'h0000_0099, 32'h0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1; idle();
    #1;
    checks++;
    if (retire_count !== 64'd0) begin
      errors++;
      $display("FAIL midreset_count: got %0d expected 0", retire_count);
    end
    for (int r = 1; r < 32; r++) begin
      rs1_addr = 5'(r); rs2_addr = 5'(31 - r + 1);
      #1;
      checks++;
      if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
        errors++;
        $display("FAIL midreset_x%0d: rs1=%h rs2=%h expected 0", r, rs1_data, rs2_data);
      end
    end
  endtask

  initial begin
    rst = 1'b0; idle(); rs1_addr = '0; rs2_addr = '0;
    #2;
    test_reset();
    test_write_read();
    test_load_bypass();
    test_x0();
    test_stall_bubble();
    test_back_to_back();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-side consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value (ALU result or load data), writes it into a 32x32 integer register file, and serves two combinational decode-stage read ports with same-cycle write-to-read bypass.
- Also maintains a 64-bit retired-instruction counter for performance/CSR readout.
- Sits between the MEM/WB register and the ID stage.

Parameters:
- XLEN, 32, data width of registers and writeback path.
- NREGS, 32, number of architectural registers; x0 hardwired to zero.
- RETW, 64, retired-instruction counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- en  in  1  writeback enable; 0 = stall, no state update
- wb_valid  in  1  MEM/WB slot holds a real instruction (not bubble)
- wb_alu_out  in  XLEN  ALU result from MEM/WB
- wb_data_out  in  XLEN  load data from MEM/WB
- wb_rd  in  5  destination register index
- wb_reg_write  in  1  register write request
- wb_mem_to_reg  in  1  1 = write load data, 0 = write ALU result
- rs1_addr  in  5  read port 1 index
- rs2_addr  in  5  read port 2 index
- rs1_data  out  XLEN  read port 1 data
- rs2_data  out  XLEN  read port 2 data
- wb_value  out  XLEN  selected writeback value, exported for EX forwarding
- retire_count  out  RETW  number of retired instructions

Behaviour:
- Clock and reset: clk is the clock; rst is synchronous and active-low, sampled at posedge clk.
- Reset (rst=0 at posedge):
  - All registers x1..x31 cleared to 0.
  - retire_count cleared to 0.
  - Reset overrides en and any pending write; a write presented in the reset cycle is discarded.
- Writeback value (combinational): wb_value = wb_mem_to_reg ? wb_data_out : wb_alu_out. It is driven regardless of en and wb_valid.
- Write qualifier: we = en & wb_valid & wb_reg_write & (wb_rd != 0).
  - When rst=1 and we=1 at posedge, regs[wb_rd] <= wb_value.
  - Writes to x0 are silently dropped; x0 always reads 0.
- Read ports (combinational, zero latency). For each port p:
  - If addr_p == 0: data = 0.
  - Else if we and addr_p == wb_rd: data = wb_value (bypass; write-before-read in the same cycle).
  - Else: data = regs[addr_p].
  - Both ports may read the same register, and both may bypass simultaneously.
- Retire counter:
  - When rst=1, en=1 and wb_valid=1 at posedge, retire_count increments by 1, independent of wb_reg_write.
  - Stores, branches and x0 writes therefore count as retired.
  - Wraps modulo 2^RETW, from all-ones to 0, with no flag.
- Stall: en=0 freezes all state. Reads and the bypass qualifier still evaluate combinationally, and we=0, so there is no bypass during a stall.
- Bubbles: wb_valid=0 means no write, no count and no bypass, even if wb_reg_write=1.
- After reset release, the first posedge with a valid write takes effect immediately; there are no warm-up cycles.

Optional Feature:
- Macro: WB_TRACE_EN.
- With the macro defined, the block gains:
  - Input wb_instr[31:0].
  - Outputs trace_valid, trace_instr[31:0], trace_rd[4:0], trace_value[XLEN-1:0], registered one cycle after each retire event.
  - trace_valid pulses for one cycle per retire.
  - All trace outputs reset to 0.
  - trace_rd and trace_value are 0 when the retiring instruction performed no register write.
- Without the macro: the trace ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - XLEN, NREGS, RETW and REG_ZERO (5'd0) constants.
  - Writeback-select encoding (WB_SEL_ALU=0, WB_SEL_MEM=1).
  - A trace-record struct used when WB_TRACE_EN is defined.
- One natural sub-module, regfile_2r1w: the storage array with two bypassed read ports and x0 handling.
- The top level adds the writeback mux, the write qualifier, the retire counter and the trace logic.

Test Plan:
- Reset: hold rst=0 for 2 cycles with we-qualifying inputs -> all rs reads 0, retire_count=0, no write lands.
- Write/read: write x5=0xDEADBEEF (mem_to_reg=0, valid=1, en=1); next cycle rs1_addr=5 -> 0xDEADBEEF, retire_count=1.
- Load select and bypass: wb_mem_to_reg=1, wb_data_out=0x12345678, wb_rd=7, rs1_addr=rs2_addr=7 in the same cycle -> both read 0x12345678 before the edge, and the value persists after it.
- x0 protection: write x0=0xFFFFFFFF with rs1_addr=0 -> rs1_data=0 in that cycle and afterwards; retire_count still increments.
- Stall and bubble: en=0 with a write to x3=0x55 -> x3 unchanged, no bypass, count unchanged; en=1 with wb_valid=0 -> likewise unchanged.
- Counter wrap: force retire_count to 2^64-1, retire once -> 0; then assert rst=0 mid-stream -> count=0 and x1..x31=0 on the next edge.
